sdspi_dumper: RTL
=================

# sdspi_dumper

Copies a fixed-size RAM region to consecutive microSD sectors, the write-direction counterpart of the SD-to-RAM boot loader. Fetches 32-bit words from the RAM controller, packs them little-endian into a 512-byte sector buffer, then feeds that buffer byte-by-byte to the SD SPI write engine, one sector at a time. It sits between the memory controller port and the SD write engine in the example SoC and is used to save RAM images back to the card.

## Interface
Parameters:
- SECTOR_BYTES, 512, sector size in bytes (power of two).
- DUMP_BYTES, 4096, number of RAM bytes to save (≥1).
- BASE_ADDR, 32'h0, RAM byte address of first word (4-byte aligned).
- START_SECTOR, 0, first SD sector written.

Ports:
- clk27mhz  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse that begins a dump; ignored unless idle.
- mem_req  out  1  RAM read request, held until mem_ack.
- mem_addr  out  32  RAM byte address, stable while mem_req=1.
- mem_rdata  in  32  read data, valid in mem_ack cycle.
- mem_ack  in  1  single-cycle read acknowledge.
- wstart  out  1  sector write request to SD engine, held until wdone/werr.
- wsector  out  32  target sector, stable while wstart=1.
- inbyte  out  8  current byte offered to SD engine.
- inreq  in  1  SD engine consumed inbyte; single-cycle pulse.
- wdone  in  1  sector written OK; single-cycle pulse.
- werr  in  1  sector write failed; single-cycle pulse.
- busy  out  1  dump in progress.
- done  out  1  dump completed; held until next start or reset.
- error  out  1  dump aborted by werr; held until next start or reset.

## Operation
- States: IDLE, FILL, WRITE, NEXT, FINISH, FAIL.
- IDLE: start=1 → clear done/error, byte counter=0, sector=START_SECTOR, busy=1, → FILL.
- FILL: for buffer word w (0..SECTOR_BYTES/4-1), global byte g = sector_offset+4w. If g < DUMP_BYTES: mem_req=1, mem_addr=BASE_ADDR+g; on mem_ack store buf[4w]=rdata[7:0] … buf[4w+3]=rdata[31:24]. Bytes with global index ≥ DUMP_BYTES written as 8'h00 without a RAM access (one word per cycle). After last word → WRITE with byte index=0, inbyte=buf[0].
- WRITE: wstart=1, wsector=current sector. Each inreq: index+1, inbyte=buf[index+1] next cycle. inreq after index reaches SECTOR_BYTES-1 ignored (inbyte holds last byte). wdone → wstart=0, → NEXT. werr → wstart=0, → FAIL. wdone and werr same cycle → FAIL.
- NEXT: sector+1, sector_offset+=SECTOR_BYTES; if sector_offset ≥ DUMP_BYTES → FINISH else → FILL.
- FINISH: done=1, busy=0, → IDLE. FAIL: error=1, busy=0, → IDLE.
- Sectors written = ceil(DUMP_BYTES/SECTOR_BYTES); partial last word/sector zero-padded.
- start while busy ignored. Address/sector arithmetic 32-bit, wrap unchecked.

## Timing
- Reset values: mem_req=0, mem_addr=0, wstart=0, wsector=0, inbyte=0, busy=0, done=0, error=0; FSM IDLE, buffer content undefined.
- Reset mid-operation: all outputs to reset values next edge; an in-flight mem_ack or wdone after reset is ignored.
- start sampled → busy=1 next cycle; first mem_req one cycle after entering FILL.
- mem_req drops the cycle after mem_ack; next request (new address) asserted the following cycle (≥1 idle cycle between requests). mem_ack may arrive any number of cycles after mem_req, including the first.
- inbyte updated registered: valid one cycle after inreq; SD engine guarantees ≥2 cycles between inreq pulses.
- wstart rises on WRITE entry, falls the cycle after wdone/werr; wsector constant throughout.
- done/error asserted 2 cycles after the final wdone/werr.

## Test plan
- DUMP_BYTES=8, RAM {32'h44332211, 32'h88776655}, 1-cycle ack → one sector 0 bytes 11,22,…,88 then 504×00; done=1, error=0.
- DUMP_BYTES=1030, random ack latency 0–5 → wsector 0,1,2; sector 2 holds bytes 1024–1029 (1030–1031 zeroed from last word), rest 00; exactly 258 mem_req handshakes.
- werr pulsed during sector 1 of 3 → wstart drops, error=1, done=0, no sector 2 request, busy=0.
- start pulsed again during WRITE → ignored, sector sequence and counts unchanged.
- resetn low mid-FILL with mem_req pending → mem_req=0 next edge; late mem_ack ignored; fresh start redoes from START_SECTOR.
- inreq pulsed 520 times in one sector → bytes 0–511 correct, inbyte stays buf[511] for extra requests.

Source files
------------

// File: rtl/sdspi_dumper.sv
// sdspi_dumper: copies a fixed RAM region to consecutive SD sectors.
// Each sector is gathered into a local byte buffer (32-bit RAM words packed
// little-endian, zero padding past the end of the region). The buffer is then
// streamed byte-by-byte to the SD SPI write engine. All outputs are registered.
module sdspi_dumper #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned DUMP_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] START_SECTOR = 32'h0000_0000
) (
  input  logic        clk27mhz,
  input  logic        resetn,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wstart,
  output logic [31:0] wsector,
  output logic [7:0]  inbyte,
  input  logic        inreq,
  input  logic        wdone,
  input  logic        werr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WORDS = SECTOR_BYTES / 4;
  localparam int unsigned WW    = $clog2(WORDS);
  localparam int unsigned BW    = WW + 2;

  localparam logic [31:0]   DUMP_W     = 32'(DUMP_BYTES);
  localparam logic [31:0]   SECT_W     = 32'(SECTOR_BYTES);
  localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(SECTOR_BYTES - 1);
  localparam logic [BW-1:0] FIRST_BYTE = BW'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // Zero every byte of a fetched word whose global index lies past the region.
  function automatic logic [31:0] pad_word(input logic [31:0] data,
                                           input logic [31:0] gidx);
    logic [31:0] w;
    w = data;
    for (int k = 0; k < 4; k++) begin
      if ((gidx + 32'(k)) >= DUMP_W) begin
        w[8*k +: 8] = 8'h00;
      end else begin
        w[8*k +: 8] = data[8*k +: 8];
      end
    end
    return w;
  endfunction

  state_t        state_r,   state_s;
  logic          mem_req_r, mem_req_s;
  logic [31:0]   mem_addr_r, mem_addr_s;
  logic          wstart_r,  wstart_s;
  logic [31:0]   wsector_r, wsector_s;
  logic [7:0]    inbyte_r,  inbyte_s;
  logic          busy_r,    busy_s;
  logic          done_r,    done_s;
  logic          error_r,   error_s;
  logic [31:0]   sector_r,  sector_s;
  logic [31:0]   offset_r,  offset_s;   // global byte index of buffer byte 0
  logic [WW-1:0] word_r,    word_s;     // buffer word being filled
  logic [BW-1:0] idx_r,     idx_s;      // buffer byte currently offered

  logic [7:0]    buf_r [SECTOR_BYTES];
  logic          buf_we_s;
  logic [31:0]   buf_wdata_s;
  logic          word_done_s;

  logic [31:0]   g_s;
  logic          need_ram_s;

  assign g_s        = offset_r + {{(32-BW){1'b0}}, word_r, 2'b00};
  assign need_ram_s = (g_s < DUMP_W);

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign wstart   = wstart_r;
  assign wsector  = wsector_r;
  assign inbyte   = inbyte_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_addr_s  = mem_addr_r;
    wstart_s    = wstart_r;
    wsector_s   = wsector_r;
    inbyte_s    = inbyte_r;
    busy_s      = busy_r;
    done_s      = done_r;
    error_s     = error_r;
    sector_s    = sector_r;
    offset_s    = offset_r;
    word_s      = word_r;
    idx_s       = idx_r;
    buf_we_s    = 1'b0;
    buf_wdata_s = 32'h0000_0000;
    word_done_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          done_s   = 1'b0;
          error_s  = 1'b0;
          busy_s   = 1'b1;
          offset_s = 32'h0000_0000;
          sector_s = START_SECTOR;
          word_s   = '0;
          state_s  = ST_FILL;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (need_ram_s) begin
          if (mem_req_r) begin
            if (mem_ack) begin
              // Drop the request now; the next one goes out a cycle later.
              mem_req_s   = 1'b0;
              buf_we_s    = 1'b1;
              buf_wdata_s = pad_word(mem_rdata, g_s);
              word_done_s = 1'b1;
            end else begin
              mem_req_s   = 1'b1;
            end
          end else begin
            mem_req_s  = 1'b1;
            mem_addr_s = BASE_ADDR + g_s;
          end
        end else begin
          // Beyond the region: pad with zeros, no RAM access.
          buf_we_s    = 1'b1;
          buf_wdata_s = 32'h0000_0000;
          word_done_s = 1'b1;
        end

        if (word_done_s) begin
          if (word_r == LAST_WORD) begin
            word_s    = '0;
            idx_s     = FIRST_BYTE;
            inbyte_s  = buf_r[FIRST_BYTE];
            wstart_s  = 1'b1;
            wsector_s = sector_r;
            state_s   = ST_WRITE;
          end else begin
            word_s    = word_r + WW'(1);
          end
        end else begin
          word_s = word_r;
        end
      end

      ST_WRITE: begin
        if (werr) begin
          // Error wins when both completion pulses arrive together.
          wstart_s = 1'b0;
          state_s  = ST_FAIL;
        end else if (wdone) begin
          wstart_s = 1'b0;
          state_s  = ST_NEXT;
        end else if (inreq && (idx_r != LAST_BYTE)) begin
          idx_s    = idx_r + BW'(1);
          inbyte_s = buf_r[idx_r + BW'(1)];
        end else begin
          // Requests past the last byte keep offering that byte.
          idx_s    = idx_r;
        end
      end

      ST_NEXT: begin
        sector_s = sector_r + 32'd1;
        offset_s = offset_r + SECT_W;
        if ((offset_r + SECT_W) >= DUMP_W) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_FINISH;
        end else begin
          state_s = ST_FILL;
        end
      end

      ST_FINISH: begin
        state_s = ST_IDLE;
      end

      ST_FAIL: begin
        error_s = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end

      default: begin
        mem_req_s = 1'b0;
        wstart_s  = 1'b0;
        busy_s    = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers with synchronous active-low reset.
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      wstart_r   <= 1'b0;
      wsector_r  <= 32'h0000_0000;
      inbyte_r   <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      sector_r   <= 32'h0000_0000;
      offset_r   <= 32'h0000_0000;
      word_r     <= '0;
      idx_r      <= '0;
    end else begin
      state_r    <= state_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      wstart_r   <= wstart_s;
      wsector_r  <= wsector_s;
      inbyte_r   <= inbyte_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
      sector_r   <= sector_s;
      offset_r   <= offset_s;
      word_r     <= word_s;
      idx_r      <= idx_s;
    end
  end

  // Sector buffer: one little-endian word per write, contents need no reset.
  always_ff @(posedge clk27mhz) begin
    if (buf_we_s) begin
      buf_r[{word_r, 2'd0}] <= buf_wdata_s[7:0];
      buf_r[{word_r, 2'd1}] <= buf_wdata_s[15:8];
      buf_r[{word_r, 2'd2}] <= buf_wdata_s[23:16];
      buf_r[{word_r, 2'd3}] <= buf_wdata_s[31:24];
    end
  end

endmodule
